// File: rtl/tdm_demux.sv
// Time-division demultiplexer: one interleaved sample stream in, one aligned LANES-wide frame out.
// Latency: OUT/OUT_VALID update on the same edge that samples the last lane beat; one-cycle strobes.
// Backpressure: none. Every valid beat is consumed at 1 sample/clock, and back-to-back frames need no bubble.
//
// Ports:
//   CLK       rising-edge clock
//   RST       asynchronous, active-low reset
//   IN        input sample (DATA_WIDTH)
//   IN_VALID  IN carries a beat this cycle
//   SOF       beat is lane 0 of a new frame (ignored when IN_VALID=0)
//   OUT       last complete frame, lane i at OUT[i*DATA_WIDTH +: DATA_WIDTH]
//   OUT_VALID one-cycle strobe, OUT updated this cycle
//   LANE_ERR  one-cycle strobe on a framing violation
//
// Optional feature: define TDM_DEMUX_LANE_ERR_EN to build the LANE_ERR register.
// When the macro is undefined, LANE_ERR is constant 0 and the datapath is unchanged.

module tdm_demux #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 2   // legal range 2..16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         IN,
  input  logic                          IN_VALID,
  input  logic                          SOF,
  output logic [LANES*DATA_WIDTH-1:0]   OUT,
  output logic                          OUT_VALID,
  output logic                          LANE_ERR
);

  localparam int              CNT_W     = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [CNT_W-1:0]          r_lane_cnt;
  // The last lane never needs storage: it goes straight from IN into OUT.
  logic [DATA_WIDTH-1:0]     r_shadow [LANES-1];
  logic [LANES*DATA_WIDTH-1:0] r_out;
  logic                      r_out_valid;
  logic [LANES*DATA_WIDTH-1:0] w_frame;

  logic w_start;   // load lane 0 and (re)start a frame
  logic w_store;   // store a middle lane into the shadow
  logic w_done;    // final lane arrived, publish the frame
`ifdef TDM_DEMUX_LANE_ERR_EN
  logic w_err;
  logic r_lane_err;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_store      = 1'b0;
    w_done       = 1'b0;
`ifdef TDM_DEMUX_LANE_ERR_EN
    w_err        = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (IN_VALID) begin
          if (SOF) begin
            w_start      = 1'b1;
            w_next_state = S_COLLECT;
          end else begin
            // Orphan beat: dropped, state stays IDLE.
`ifdef TDM_DEMUX_LANE_ERR_EN
            w_err = 1'b1;
`endif
          end
        end
      end
      S_COLLECT: begin
        if (IN_VALID) begin
          if (SOF) begin
            // Early SOF: abandon the partial frame and restart on this beat.
            w_start = 1'b1;
`ifdef TDM_DEMUX_LANE_ERR_EN
            w_err   = 1'b1;
`endif
          end else if (r_lane_cnt == LAST_LANE) begin
            w_done       = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_store = 1'b1;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Completed frame: stored lanes below, the live beat on top.
  always_comb begin
    w_frame = '0;
    for (int i = 0; i < LANES - 1; i++) begin
      w_frame[i*DATA_WIDTH +: DATA_WIDTH] = r_shadow[i];
    end
    w_frame[(LANES-1)*DATA_WIDTH +: DATA_WIDTH] = IN;
  end

  // Datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_lane_cnt  <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < LANES - 1; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_out_valid <= w_done;
      if (w_start) begin
        r_shadow[0] <= IN;
        r_lane_cnt  <= CNT_W'(1);
      end else if (w_store) begin
        for (int i = 1; i < LANES - 1; i++) begin
          if (r_lane_cnt == CNT_W'(i)) begin
            r_shadow[i] <= IN;
          end
        end
        r_lane_cnt <= r_lane_cnt + CNT_W'(1);
      end else if (w_done) begin
        r_out      <= w_frame;
        r_lane_cnt <= '0;
      end
    end
  end

`ifdef TDM_DEMUX_LANE_ERR_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_lane_err <= 1'b0;
    end else begin
      r_lane_err <= w_err;
    end
  end
  assign LANE_ERR = r_lane_err;
`else
  assign LANE_ERR = 1'b0;
`endif

  assign OUT       = r_out;
  assign OUT_VALID = r_out_valid;

endmodule
